// File: rtl/bht_trainer.sv
// ---------------------------------------------------------------------------
// bht_trainer
//   Training side of the branch predictor. Resolved conditional branches from
//   commit are buffered in a small FIFO. A three-state FSM drains the FIFO and
//   applies each outcome to a table of 2-bit saturating counters, one update
//   every three cycles (pop, read, write). The table is read combinationally
//   by fetch through the query port. Branch and mispredict totals are counted
//   when an update is accepted.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   upd_valid        commit offers a resolved branch
//   upd_ready        buffer not full (occupancy only, independent of valid)
//   upd_pc           pc of the resolved branch; index = pc[BHT_IDX_W+1:2]
//   upd_taken        actual outcome
//   upd_mispredict   fetch mispredicted this branch (statistics only)
//   query_pc         fetch-side lookup pc
//   query_taken      MSB of the counter at the query index
//   busy             buffer non-empty or an update in flight
//   branch_cnt       accepted updates since reset
//   mispredict_cnt   accepted updates flagged as mispredicted
// ---------------------------------------------------------------------------
module bht_trainer #(
  parameter int BHT_IDX_W  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic [ADDR_W-1:0] query_pc,
  output logic              query_taken,
  output logic              busy,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispredict_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRIES = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // ---------------------------------------------------------------------------
  // Index extraction (word-aligned pcs, low two bits dropped)
  // ---------------------------------------------------------------------------
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] query_idx;

  assign upd_idx   = upd_pc[BHT_IDX_W+1:2];
  assign query_idx = query_pc[BHT_IDX_W+1:2];

  // Bits of the pcs that do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[ADDR_W-1:BHT_IDX_W+2], upd_pc[1:0],
                            query_pc[ADDR_W-1:BHT_IDX_W+2], query_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Update FIFO
  // ---------------------------------------------------------------------------
  logic [BHT_IDX_W-1:0] fifo_idx_q   [FIFO_DEPTH];
  logic                 fifo_taken_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 push;
  logic                 pop;

  assign upd_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = upd_valid && upd_ready;

  // Pointers are PTR_W bits wide and FIFO_DEPTH is a power of two, so plain
  // increment wraps modulo the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO payload storage is left unreset; an entry is only read after a
  // push has written it, and the pointers/occupancy carry all control state.
  // The counter table below, by contrast, must come out of reset at 2'b01.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]   <= upd_idx;
      fifo_taken_q[wr_ptr_q] <= upd_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Update FSM: IDLE pops, RD latches the old counter, WR commits the new one.
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [BHT_IDX_W-1:0] work_idx_q;
  logic                 work_taken_q;
  logic [1:0]           cnt_q;
  logic                 tbl_we;
  logic [1:0]           cnt_new;
  logic [1:0]           table_q [ENTRIES];

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    pop     = 1'b0;
    tbl_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD:    state_d = S_WR;
      S_WR: begin
        tbl_we  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_new = work_taken_q ? sat_inc(cnt_q) : sat_dec(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      work_idx_q   <= '0;
      work_taken_q <= 1'b0;
      cnt_q        <= 2'b01;
    end else begin
      state_q <= state_d;
      if (pop) begin
        work_idx_q   <= fifo_idx_q[rd_ptr_q];
        work_taken_q <= fifo_taken_q[rd_ptr_q];
      end
      if (state_q == S_RD) cnt_q <= table_q[work_idx_q];
    end
  end

  // Reset has priority over the WR-state write, so an update in flight when
  // reset arrives never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
    end else if (tbl_we) begin
      table_q[work_idx_q] <= cnt_new;
    end
  end

  // No write bypass: a same-cycle write to the queried index is seen next cycle.
  assign query_taken = table_q[query_idx][1];

  assign busy = (count_q != '0) || (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Statistics, counted at accept time
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (push) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (upd_mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bht_trainer.sv
// ---------------------------------------------------------------------------
// tb_bht_trainer
//   Directed bench for bht_trainer. Inputs change on the falling edge and
//   outputs are sampled on the falling edge (plus #1 after a query change),
//   well away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_bht_trainer;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] query_pc;
  logic        query_taken;
  logic        busy;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;
  int exp_branch = 0;
  int exp_misp   = 0;

  bht_trainer #(.BHT_IDX_W(8), .FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .query_pc       (query_pc),
    .query_taken    (query_taken),
    .busy           (busy),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] pc, input logic exp);
    query_pc = pc;
    #1;
    check(tag, {31'd0, query_taken}, {31'd0, exp});
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_branch"}, branch_cnt, exp_branch);
    check({tag, "_misp"}, mispredict_cnt, exp_misp);
  endtask

  // Called on a falling edge; returns on a falling edge with upd_valid low.
  task automatic push(input logic [31:0] pc, input logic taken, input logic misp);
    int waited;
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_mispredict = misp;
    waited = 0;
    while (!upd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!upd_ready) begin
      check("push_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      exp_branch++;
      if (misp) exp_misp++;
    end
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while (busy && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_branch = 0;
    exp_misp   = 0;
  endtask

  initial begin
    rst            = 1'b1;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    query_pc       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- Reset then idle ----
    check_q("rst_q0", 32'h0, 1'b0);
    check_q("rst_q100", 32'h100, 1'b0);
    check_q("rst_qffc", 32'hFFC, 1'b0);
    check("rst_ready", {31'd0, upd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_stats("rst");

    // ---- Latency: accept at E, table visible from E+3 ----
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_mispredict = 1'b0;
    query_pc  = 32'h200;
    #1 check("lat_ready", {31'd0, upd_ready}, 32'd1);
    @(posedge clk);              // edge E
    exp_branch++;
    @(negedge clk);
    upd_valid = 1'b0;
    check("lat_busy", {31'd0, busy}, 32'd1);
    check_q("lat_e0", 32'h200, 1'b0);
    @(negedge clk);              // after E+1
    check_q("lat_e1", 32'h200, 1'b0);
    @(negedge clk);              // after E+2
    check_q("lat_e2", 32'h200, 1'b0);
    @(negedge clk);              // after E+3
    check_q("lat_e3", 32'h200, 1'b1);
    wait_idle("lat_idle");

    // ---- Saturation at pc 0x100 (idx 0x40), counter starts at 01 ----
    push(32'h100, 1'b1, 1'b0); wait_idle("sat_idle1");
    check_q("sat_t1_10", 32'h100, 1'b1);
    push(32'h100, 1'b1, 1'b0); wait_idle("sat_idle2");
    check_q("sat_t2_11", 32'h100, 1'b1);
    push(32'h100, 1'b1, 1'b0); wait_idle("sat_idle3");
    check_q("sat_t3_11", 32'h100, 1'b1);
    push(32'h100, 1'b0, 1'b0); wait_idle("sat_idle4");
    check_q("sat_n1_10", 32'h100, 1'b1);
    push(32'h100, 1'b0, 1'b0);
    push(32'h100, 1'b0, 1'b0); wait_idle("sat_idle5");
    check_q("sat_n3_00", 32'h100, 1'b0);
    push(32'h100, 1'b0, 1'b0); wait_idle("sat_idle6");
    check_q("sat_n4_00", 32'h100, 1'b0);
    // From 00 one taken gives 01 (still 0); a wrapped 00->11 would show 1.
    push(32'h100, 1'b1, 1'b0); wait_idle("sat_idle7");
    check_q("sat_t_01", 32'h100, 1'b0);
    check_stats("sat");

    // ---- Backpressure: valid held 8 cycles, pcs 0x300+4i (idx 0xC0+i) ----
    // From empty/IDLE the buffer reaches 4 after the 6th edge, so cycles 6
    // and 7 are refused.
    for (int i = 0; i < 8; i++) begin
      upd_valid      = 1'b1;
      upd_pc         = 32'h300 + 32'(4 * i);
      upd_taken      = 1'b1;
      upd_mispredict = 1'b0;
      #1 check($sformatf("bp_ready%0d", i), {31'd0, upd_ready}, (i < 6) ? 32'd1 : 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    exp_branch += 6;
    wait_idle("bp_idle");
    for (int i = 0; i < 8; i++)
      check_q($sformatf("bp_q%0d", i), 32'h300 + 32'(4 * i), i < 6);
    check_stats("bp");

    // ---- Reset mid-operation: 3 queued, reset while FSM in WR ----
    upd_valid = 1'b1; upd_taken = 1'b1; upd_mispredict = 1'b1;
    upd_pc = 32'h600; @(posedge clk); @(negedge clk);   // e1: accept
    upd_pc = 32'h604; @(posedge clk); @(negedge clk);   // e2: accept, pop
    upd_pc = 32'h608; @(posedge clk); @(negedge clk);   // e3: accept, RD->WR
    upd_valid = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    do_reset();
    check_q("mid_q600", 32'h600, 1'b0);
    check_q("mid_q100", 32'h100, 1'b0);
    check_q("mid_q300", 32'h300, 1'b0);
    check_q("mid_q200", 32'h200, 1'b0);
    check("mid_ready", {31'd0, upd_ready}, 32'd1);
    check("mid_busy0", {31'd0, busy}, 32'd0);
    check_stats("mid");
    repeat (8) @(negedge clk);
    check("mid_late_busy", {31'd0, busy}, 32'd0);
    check_q("mid_late_q600", 32'h600, 1'b0);
    check_q("mid_late_q604", 32'h604, 1'b0);

    // ---- Aliasing: 0x100 and 0x500 share idx 0x40, applied in order ----
    push(32'h100, 1'b1, 1'b0);
    push(32'h500, 1'b1, 1'b0);
    wait_idle("alias_idle");
    check_q("alias_q500", 32'h500, 1'b1);
    check_q("alias_q104", 32'h104, 1'b0);
    // Counter is 11 only if both updates landed on top of a 01 reset value.
    push(32'h500, 1'b0, 1'b0); wait_idle("alias_idle2");
    check_q("alias_q100_10", 32'h100, 1'b1);
    push(32'h100, 1'b0, 1'b0); wait_idle("alias_idle3");
    check_q("alias_q500_01", 32'h500, 1'b0);

    // ---- Statistics: 10 accepts, 3 mispredicted, from reset ----
    do_reset();
    for (int i = 0; i < 10; i++)
      push(32'h800 + 32'(4 * i), i[0], (i == 1 || i == 4 || i == 7));
    check("stat_branch10", branch_cnt, 32'd10);
    check("stat_misp3", mispredict_cnt, 32'd3);
    wait_idle("stat_idle");
    // Offers refused while full must not count: 8 cycles held, 6 accepted.
    for (int i = 0; i < 8; i++) begin
      upd_valid      = 1'b1;
      upd_pc         = 32'hA00 + 32'(4 * i);
      upd_taken      = 1'b0;
      upd_mispredict = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("stat_branch16", branch_cnt, 32'd16);
    check("stat_misp9", mispredict_cnt, 32'd9);
    wait_idle("stat_idle2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
